// File: rtl/disparo_pc_if.sv
`default_nettype none
// disparo_pc_if -- control, random-draw and board bus of the PC shot engine (rev 1.0).
interface disparo_pc_if #(
  parameter int N = 5
) ();
  logic       cargar;
  logic       disparar;
  logic       disparoHabilitado;
  logic [3:0] filaRandom;
  logic [3:0] columnaRandom;
  int         matrizInicialJ [N][N];
  int         matrizResJ     [N][N];
  logic       disparoListo;
  logic       impacto;
  logic       fallo;
  logic [3:0] filaDisparo;
  logic [3:0] columnaDisparo;
  logic [4:0] contadorImpactos;
  logic       juegoTerminado;

  modport slave (
    input  cargar, disparar, disparoHabilitado, filaRandom, columnaRandom, matrizInicialJ,
    output matrizResJ, disparoListo, impacto, fallo, filaDisparo, columnaDisparo,
           contadorImpactos, juegoTerminado
  );

  modport master (
    output cargar, disparar, disparoHabilitado, filaRandom, columnaRandom, matrizInicialJ,
    input  matrizResJ, disparoListo, impacto, fallo, filaDisparo, columnaDisparo,
           contadorImpactos, juegoTerminado
  );
endinterface
`default_nettype wire

// File: rtl/disparo_pc.sv
`default_nettype none
// disparo_pc -- PC shot engine: random draws, row-major fallback, hit/miss marking, game over (rev 1.0).
// Optional macro DISPARO_CAZA_EN: after a hit, probe the four neighbours before drawing at random.
module disparo_pc #(
  parameter int N            = 5,
  parameter int TOTAL_CELDAS = 15,
  parameter int MAX_REINT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  disparo_pc_if.slave bus
);
  localparam int RW = $clog2(MAX_REINT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MUESTREO  = 2'd1,
    RESULTADO = 2'd2,
    FIN       = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [1:0]    tablero [N][N];
  logic [RW-1:0] retry_cnt;
  logic [3:0]    fila_q, col_q;
  logic [4:0]    contador;
  logic          listo_q, impacto_q, fallo_q, terminado_q;

  logic          arranque, acepta, agotado, inc_retry, fin_juego;
  logic [3:0]    sel_fila, sel_col;
  logic          rand_ok, fb_ok, celda_barco;
  logic [3:0]    fb_fila, fb_col;

  // A cell may be shot when on the board and still 0 (water) or 1 (ship).
  function automatic logic celda_libre(input logic [3:0] f, input logic [3:0] c);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (f == 4'(i) && c == 4'(j) && !tablero[i][j][1]) r = 1'b1;
    return r;
  endfunction

  assign rand_ok = celda_libre(bus.filaRandom, bus.columnaRandom);

  always_comb begin
    fb_ok       = 1'b0;
    fb_fila     = 4'd0;
    fb_col      = 4'd0;
    celda_barco = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!fb_ok && !tablero[i][j][1]) begin
          fb_ok   = 1'b1;
          fb_fila = 4'(i);
          fb_col  = 4'(j);
        end
        if (fila_q == 4'(i) && col_q == 4'(j) && tablero[i][j] == 2'd1) celda_barco = 1'b1;
      end
    end
  end

`ifdef DISPARO_CAZA_EN
  logic       caza_activa;
  logic [3:0] caza_fila, caza_col;
  logic [2:0] probe_idx;
  logic [3:0] probe_fila, probe_col;
  logic       probe_en, probe_ok, adv_probe;

  // Off-board neighbours wrap to >= N in 4 bits and are rejected by celda_libre.
  always_comb begin
    probe_fila = caza_fila;
    probe_col  = caza_col;
    case (probe_idx[1:0])
      2'd0:    probe_col  = caza_col + 4'd1;
      2'd1:    probe_fila = caza_fila + 4'd1;
      2'd2:    probe_col  = caza_col - 4'd1;
      default: probe_fila = caza_fila - 4'd1;
    endcase
  end

  assign probe_en = caza_activa && !probe_idx[2];
  assign probe_ok = celda_libre(probe_fila, probe_col);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    arranque   = 1'b0;
    acepta     = 1'b0;
    agotado    = 1'b0;
    inc_retry  = 1'b0;
    fin_juego  = 1'b0;
    sel_fila   = bus.filaRandom;
    sel_col    = bus.columnaRandom;
`ifdef DISPARO_CAZA_EN
    adv_probe  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!bus.cargar && bus.disparar && bus.disparoHabilitado) begin
          arranque   = 1'b1;
          state_next = MUESTREO;
        end
      end
      MUESTREO: begin
`ifdef DISPARO_CAZA_EN
        if (probe_en) begin
          sel_fila = probe_fila;
          sel_col  = probe_col;
          if (probe_ok) acepta = 1'b1;
          else          adv_probe = 1'b1;
        end else
`endif
        if (retry_cnt == RW'(MAX_REINT)) begin
          if (fb_ok) begin
            acepta   = 1'b1;
            sel_fila = fb_fila;
            sel_col  = fb_col;
          end else begin
            agotado = 1'b1;
          end
        end else if (rand_ok) begin
          acepta = 1'b1;
        end else begin
          inc_retry = 1'b1;
        end
        if (acepta)       state_next = RESULTADO;
        else if (agotado) state_next = FIN;
      end
      RESULTADO: begin
        fin_juego  = celda_barco && ((contador + 5'd1) >= 5'(TOTAL_CELDAS));
        state_next = fin_juego ? FIN : IDLE;
      end
      FIN: begin
        if (bus.cargar) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          tablero[i][j] <= 2'd0;
      retry_cnt   <= '0;
      fila_q      <= 4'd0;
      col_q       <= 4'd0;
      contador    <= 5'd0;
      listo_q     <= 1'b0;
      impacto_q   <= 1'b0;
      fallo_q     <= 1'b0;
      terminado_q <= 1'b0;
`ifdef DISPARO_CAZA_EN
      caza_activa <= 1'b0;
      caza_fila   <= 4'd0;
      caza_col    <= 4'd0;
      probe_idx   <= 3'd0;
`endif
    end else begin
      listo_q   <= 1'b0;
      impacto_q <= 1'b0;
      fallo_q   <= 1'b0;

      if ((state == IDLE || state == FIN) && bus.cargar) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            tablero[i][j] <= (bus.matrizInicialJ[i][j] == 1) ? 2'd1 : 2'd0;
        contador    <= 5'd0;
        terminado_q <= 1'b0;
`ifdef DISPARO_CAZA_EN
        caza_activa <= 1'b0;
`endif
      end

      if (arranque) begin
        retry_cnt <= '0;
`ifdef DISPARO_CAZA_EN
        probe_idx <= 3'd0;
`endif
      end

      if (inc_retry) retry_cnt <= retry_cnt + 1'b1;

      if (acepta) begin
        fila_q <= sel_fila;
        col_q  <= sel_col;
      end

      // Board exhausted: report completion with neither hit nor miss.
      if (agotado) begin
        terminado_q <= 1'b1;
        listo_q     <= 1'b1;
      end

      if (state == RESULTADO) begin
        listo_q   <= 1'b1;
        impacto_q <= celda_barco;
        fallo_q   <= !celda_barco;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (fila_q == 4'(i) && col_q == 4'(j))
              tablero[i][j] <= celda_barco ? 2'd3 : 2'd2;
        if (celda_barco && contador < 5'(TOTAL_CELDAS)) contador <= contador + 5'd1;
        if (fin_juego) terminado_q <= 1'b1;
`ifdef DISPARO_CAZA_EN
        caza_activa <= celda_barco;
        if (celda_barco) begin
          caza_fila <= fila_q;
          caza_col  <= col_q;
        end
`endif
      end

`ifdef DISPARO_CAZA_EN
      if (adv_probe) probe_idx <= probe_idx + 3'd1;
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.matrizResJ[i][j] = int'(tablero[i][j]);
  end

  assign bus.disparoListo     = listo_q;
  assign bus.impacto          = impacto_q;
  assign bus.fallo            = fallo_q;
  assign bus.filaDisparo      = fila_q;
  assign bus.columnaDisparo   = col_q;
  assign bus.contadorImpactos = contador;
  assign bus.juegoTerminado   = terminado_q;

endmodule
`default_nettype wire
